logic16_pipe: RTL and testbench

Parametrised, pipelined successor to the 16-bit bitwise gate arrays. One unit performs all eight bitwise operations on WIDTH-bit operands, selected per transaction, through a two-stage valid/ready pipeline. It adds status flags, an accumulate mode that chains the previous result in as operand B, and a completed-transaction counter. It sits between the operand/decoder logic and the writeback path of the ALU datapath.

---
 rtl/logic16_pipe.sv | 139 +++++++++++++
 tb/tb_logic16_pipe.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/logic16_pipe.sv
// Two-stage valid/ready bitwise logic unit with status flags, accumulate mode
// (previous result chained in as operand B) and a completed-result counter.
module logic16_pipe #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             neg,
  output logic             parity,
  output logic [CNT_W-1:0] count
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [2:0]       s1_op_q, s1_op_d;
  logic             s1_acc_q, s1_acc_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             parity_q, parity_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             s2_adv;
  logic             in_fire;
  logic             out_fire;
  logic [WIDTH-1:0] opnd_b;
  logic [WIDTH-1:0] result;

  assign s2_adv   = s1_valid_q & (~s2_valid_q | out_ready);
  assign in_ready = ~s1_valid_q | s2_adv;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = s2_valid_q & out_ready;

  // y_q still holds the preceding transaction's result when S2 loads, so
  // back-to-back accumulation needs no bubble.
  assign opnd_b = s1_acc_q ? y_q : s1_b_q;

  always_comb begin
    result = '0;
    case (s1_op_q)
      3'b000:  result = s1_a_q & opnd_b;
      3'b001:  result = s1_a_q | opnd_b;
      3'b010:  result = s1_a_q ^ opnd_b;
      3'b011:  result = ~(s1_a_q & opnd_b);
      3'b100:  result = ~(s1_a_q | opnd_b);
      3'b101:  result = ~(s1_a_q ^ opnd_b);
      3'b110:  result = ~s1_a_q;
      default: result = s1_a_q;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s1_acc_d   = s1_acc_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_a_d     = a;
      s1_b_d     = b;
      s1_op_d    = op;
      s1_acc_d   = acc_sel;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    y_d        = y_q;
    zero_d     = zero_q;
    neg_d      = neg_q;
    parity_d   = parity_q;
    count_d    = count_q;
    if (s2_adv) begin
      s2_valid_d = 1'b1;
      y_d        = result;
      zero_d     = (result == '0);
      neg_d      = result[WIDTH-1];
      parity_d   = ^result;
    end else if (out_fire) begin
      s2_valid_d = 1'b0;
    end
    if (out_fire) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s1_acc_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      y_q        <= '0;
      zero_q     <= 1'b1;
      neg_q      <= 1'b0;
      parity_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s1_acc_q   <= s1_acc_d;
      s2_valid_q <= s2_valid_d;
      y_q        <= y_d;
      zero_q     <= zero_d;
      neg_q      <= neg_d;
      parity_q   <= parity_d;
      count_q    <= count_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign y         = y_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign parity    = parity_q;
  assign count     = count_q;

endmodule

// File: tb/tb_logic16_pipe.sv
// Directed bench for logic16_pipe: op sweep, accumulate chain, backpressure,
// counter wrap (second instance with a 3-bit counter) and mid-stream reset.
module tb_logic16_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [2:0]  op = '0;
  logic        acc_sel = 1'b0;

  logic        in_ready, out_valid, zero, neg, parity;
  logic [15:0] y;
  logic [15:0] count;

  logic        in_ready2, out_valid2, zero2, neg2, parity2;
  logic [15:0] y2;
  logic [2:0]  count2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  logic16_pipe #(.WIDTH(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc_sel(acc_sel), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .zero(zero), .neg(neg), .parity(parity),
    .count(count)
  );

  logic16_pipe #(.WIDTH(16), .CNT_W(3)) dut_w3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .op(op), .acc_sel(acc_sel), .out_valid(out_valid2),
    .out_ready(out_ready), .y(y2), .zero(zero2), .neg(neg2), .parity(parity2),
    .count(count2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_y(input string tag, input logic [15:0] e);
    chk({tag, ".y"}, {16'h0, y}, {16'h0, e});
    chk({tag, ".zero"}, {31'h0, zero}, {31'h0, (e == 16'h0)});
    chk({tag, ".neg"}, {31'h0, neg}, {31'h0, e[15]});
    chk({tag, ".parity"}, {31'h0, parity}, {31'h0, ^e});
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic [15:0] sweep_exp [8];

  initial begin
    sweep_exp = '{16'hF000, 16'hFFF0, 16'h0FF0, 16'h0FFF,
                  16'h000F, 16'hF00F, 16'h0F0F, 16'hF0F0};

    // reset
    #2 rst_n = 1'b0;
    tick();
    tick();
    chk("rst.out_valid", {31'h0, out_valid}, 32'h0);
    chk_y("rst", 16'h0000);
    chk("rst.count", {16'h0, count}, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rst.in_ready", {31'h0, in_ready}, 32'h1);

    // op sweep, back-to-back
    a = 16'hF0F0;
    b = 16'hFF00;
    acc_sel = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        in_valid = 1'b1;
        op = 3'(i);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i >= 1 && i <= 8) begin
        chk($sformatf("sweep%0d.out_valid", i - 1), {31'h0, out_valid}, 32'h1);
        chk_y($sformatf("sweep%0d", i - 1), sweep_exp[i-1]);
      end
      if (i == 9) chk("sweep.drain_valid", {31'h0, out_valid}, 32'h0);
    end
    chk("sweep.count", {16'h0, count}, 32'd8);
    chk("sweep.count_w3", {29'h0, count2}, 32'd0);

    // accumulate chain
    pulse_reset();
    in_valid = 1'b1; acc_sel = 1'b1; b = 16'hFFFF;
    a = 16'h0001; op = 3'b001;
    tick();
    a = 16'h0002; op = 3'b001;
    tick();
    chk_y("acc0", 16'h0001);
    a = 16'h00FF; op = 3'b010;
    tick();
    chk_y("acc1", 16'h0003);
    in_valid = 1'b0;
    tick();
    chk_y("acc2", 16'h00FC);

    // zero flag after a nonzero result
    in_valid = 1'b1; acc_sel = 1'b0; a = 16'h00FF; b = 16'hFF00; op = 3'b000;
    tick();
    in_valid = 1'b0;
    tick();
    chk_y("and_zero", 16'h0000);

    // backpressure
    pulse_reset();
    out_ready = 1'b1; op = 3'b111; acc_sel = 1'b0; b = 16'h0;
    in_valid = 1'b1; a = 16'd1;
    tick();
    a = 16'd2;
    tick();
    chk_y("bp.first", 16'd1);
    out_ready = 1'b0;
    a = 16'd3;
    #1 chk("bp.in_ready_full", {31'h0, in_ready}, 32'h0);
    for (int s = 0; s < 4; s++) begin
      tick();
      chk($sformatf("bp.stall%0d.valid", s), {31'h0, out_valid}, 32'h1);
      chk($sformatf("bp.stall%0d.y", s), {16'h0, y}, 32'd1);
      chk($sformatf("bp.stall%0d.in_ready", s), {31'h0, in_ready}, 32'h0);
    end
    chk("bp.stall_count", {16'h0, count}, 32'd0);
    out_ready = 1'b1;
    tick();
    chk_y("bp.r2", 16'd2);
    a = 16'd4;
    tick();
    chk_y("bp.r3", 16'd3);
    a = 16'd5;
    tick();
    chk_y("bp.r4", 16'd4);
    in_valid = 1'b0;
    tick();
    chk_y("bp.r5", 16'd5);
    tick();
    chk("bp.drain_valid", {31'h0, out_valid}, 32'h0);
    chk("bp.y_retained", {16'h0, y}, 32'd5);
    chk("bp.count", {16'h0, count}, 32'd5);

    // four more results -> 9 total, 3-bit counter wraps to 1
    in_valid = 1'b1;
    for (int k = 6; k <= 9; k++) begin
      a = 16'(k);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("wrap.count16", {16'h0, count}, 32'd9);
    chk("wrap.count3", {29'h0, count2}, 32'd1);

    // reset mid-stream with both stages full
    out_ready = 1'b0; in_valid = 1'b1; op = 3'b111;
    a = 16'hAAAA;
    tick();
    a = 16'h5555;
    tick();
    in_valid = 1'b0;
    chk("mid.pre_valid", {31'h0, out_valid}, 32'h1);
    chk("mid.pre_in_ready", {31'h0, in_ready}, 32'h0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid.out_valid", {31'h0, out_valid}, 32'h0);
    chk("mid.y", {16'h0, y}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; acc_sel = 1'b1; op = 3'b010; a = 16'h1234; b = 16'hFFFF;
    tick();
    in_valid = 1'b0;
    tick();
    chk_y("mid.acc", 16'h1234);
    tick();
    chk("mid.no_dup", {31'h0, out_valid}, 32'h0);
    chk("mid.count", {16'h0, count}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
